// File: rtl/display_pwm_modulator.sv
// Multi-channel RGB PWM modulator with period-boundary duty reload and underrun reporting.
// Optional blanking input is enabled by defining DISPLAY_PWM_BLANK_EN.
module display_pwm_modulator #(
  parameter int segments   = 1,
  parameter int cyclewidth = 8,
  parameter int prescale   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef DISPLAY_PWM_BLANK_EN
  input  logic                               blank,
`endif
  input  logic [cyclewidth*3*segments-1:0]   cpixel,
  input  logic                               cpixel_valid,
  output logic                               cpixel_ready,
  output logic [3*segments-1:0]              channel_out,
  output logic                               period_start,
  output logic                               underrun
);

  localparam int CHANNELS = 3 * segments;
  localparam int PW = (prescale > 1) ? $clog2(prescale) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(prescale - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [cyclewidth-1:0]  tick, tick_next;
  logic [PW-1:0]          presc, presc_next;
  logic [cyclewidth-1:0]  duty [CHANNELS];
  logic                   rst_q;
  logic                   last_clock;
  logic                   transfer;
  logic                   blank_now;

`ifdef DISPLAY_PWM_BLANK_EN
  assign blank_now = blank;
`else
  assign blank_now = 1'b0;
`endif

  // rst_q keeps ready low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      presc <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      presc <= presc_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick;
    presc_next = presc;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = RUN;
          tick_next  = '0;
          presc_next = '0;
        end
      end
      RUN: begin
        if (presc == PRESC_LAST) begin
          presc_next = '0;
          tick_next  = tick + 1'b1;
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last_clock   = (state == RUN) && (tick == '1) && (presc == PRESC_LAST);
    cpixel_ready = !rst_q && ((state == IDLE) || last_clock);
    transfer     = cpixel_valid && cpixel_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < CHANNELS; g++) duty[g] <= '0;
    end else if (transfer) begin
      for (int g = 0; g < CHANNELS; g++) duty[g] <= cpixel[g*cyclewidth +: cyclewidth];
    end
  end

  // Channel compare is registered, so outputs lag the tick counter by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      channel_out  <= '0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      period_start <= (state == RUN) && (tick == '0) && (presc == '0);
      underrun     <= last_clock && !transfer;
      for (int g = 0; g < CHANNELS; g++) begin
        channel_out[g] <= (state == RUN) && (tick < duty[g]) && !blank_now;
      end
    end
  end

endmodule

// File: tb/tb_display_pwm_modulator.sv
// Directed testbench for display_pwm_modulator: reset table, full-period patterns,
// underrun, mid-period reset, prescale=3 instance and (with DISPLAY_PWM_BLANK_EN) blanking.
module tb_display_pwm_modulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpixel_valid, cpixel_ready, period_start, underrun;
  logic [23:0] cpixel;
  logic [2:0]  channel_out;
  logic        rst3, valid3, ready3, ps3, ur3;
  logic [23:0] cpixel3;
  logic [2:0]  ch3;
`ifdef DISPLAY_PWM_BLANK_EN
  logic        blank;
`endif

  display_pwm_modulator #(.segments(1), .cyclewidth(8), .prescale(1)) dut (
    .clk(clk), .rst(rst),
`ifdef DISPLAY_PWM_BLANK_EN
    .blank(blank),
`endif
    .cpixel(cpixel), .cpixel_valid(cpixel_valid), .cpixel_ready(cpixel_ready),
    .channel_out(channel_out), .period_start(period_start), .underrun(underrun)
  );

  display_pwm_modulator #(.segments(1), .cyclewidth(8), .prescale(3)) dut3 (
    .clk(clk), .rst(rst3),
`ifdef DISPLAY_PWM_BLANK_EN
    .blank(1'b0),
`endif
    .cpixel(cpixel3), .cpixel_valid(valid3), .cpixel_ready(ready3),
    .channel_out(ch3), .period_start(ps3), .underrun(ur3)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [23:0] pix;
    logic        exp_rdy;
    logic [2:0]  exp_ch;
    logic        exp_ps;
    logic        exp_ur;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      pass_cnt++;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    cpixel_valid = v.valid;
    cpixel       = v.pix;
    step();
  endtask

  task automatic get_outputs(input int sel, output logic rdy, output logic [2:0] ch,
                             output logic ps, output logic ur);
    if (sel == 0) begin
      rdy = cpixel_ready; ch = channel_out; ps = period_start; ur = underrun;
    end else begin
      rdy = ready3; ch = ch3; ps = ps3; ur = ur3;
    end
  endtask

  task automatic set_valid(input int sel, input logic v, input logic [23:0] d);
    if (sel == 0) begin
      cpixel_valid = v; cpixel = d;
    end else begin
      valid3 = v; cpixel3 = d;
    end
  endtask

  task automatic wait_ps(input int sel, input int bound, input string name);
    logic rdy, ps, ur;
    logic [2:0] ch;
    logic found;
    found = 1'b0;
    for (int n = 0; n < bound && !found; n++) begin
      get_outputs(sel, rdy, ch, ps, ur);
      if (ps) found = 1'b1;
      else step();
    end
    checkOutput(name, {31'd0, found}, 32'd1);
  endtask

  // Starts on the sample showing period_start and walks one whole period.
  task automatic measure(input int sel, input int period_len, input int pre,
                         input logic [23:0] duty_now, input logic feed,
                         input logic [23:0] feed_data, input logic exp_ur,
                         input int blank_lo, input int blank_hi, input string name);
    logic rdy, ps, ur;
    logic [2:0] ch, exp_ch;
    int err_ch, err_ps, err_rdy, err_ur, t;
    logic [23:0] dv;
    err_ch = 0; err_ps = 0; err_rdy = 0; err_ur = 0;
    dv = duty_now;
    for (int i = 0; i < period_len; i++) begin
      get_outputs(sel, rdy, ch, ps, ur);
      t = i / pre;
      for (int g = 0; g < 3; g++)
        exp_ch[g] = (t < int'(dv[g*8 +: 8])) && !(t >= blank_lo && t <= blank_hi);
      if (ch !== exp_ch) err_ch++;
      if (ps !== (i == 0)) err_ps++;
      if (rdy !== (i == period_len - 2)) err_rdy++;
      if (ur !== (exp_ur && (i == period_len - 1))) err_ur++;
      set_valid(sel, feed && rdy, feed_data);
`ifdef DISPLAY_PWM_BLANK_EN
      if (sel == 0) blank = ((i + 1) / pre >= blank_lo) && ((i + 1) / pre <= blank_hi);
`endif
      step();
    end
    set_valid(sel, 1'b0, 24'h0);
`ifdef DISPLAY_PWM_BLANK_EN
    blank = 1'b0;
`endif
    checkOutput({name, "_channels"}, err_ch, 0);
    checkOutput({name, "_period_start"}, err_ps, 0);
    checkOutput({name, "_ready"}, err_rdy, 0);
    checkOutput({name, "_underrun"}, err_ur, 0);
    get_outputs(sel, rdy, ch, ps, ur);
    checkOutput({name, "_next_start"}, {31'd0, ps}, 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    logic rdy, ps, ur;
    logic [2:0] ch;
    int bad;

    rst = 1'b1; cpixel_valid = 1'b0; cpixel = '0;
    rst3 = 1'b1; valid3 = 1'b0; cpixel3 = '0;
`ifdef DISPLAY_PWM_BLANK_EN
    blank = 1'b0;
`endif

    // Channel 0 = R (low byte), 1 = G, 2 = B.
    vecs[0] = '{1'b1, 1'b0, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'h123456, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24'h0080FF, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 24'h101010, 1'b0, 3'b011, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 24'h000000, 1'b0, 3'b011, 1'b0, 1'b0};

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec%0d_ready", k), {31'd0, cpixel_ready}, {31'd0, vecs[k].exp_rdy});
      checkOutput($sformatf("vec%0d_channels", k), {29'd0, channel_out}, {29'd0, vecs[k].exp_ch});
      checkOutput($sformatf("vec%0d_period_start", k), {31'd0, period_start}, {31'd0, vecs[k].exp_ps});
      checkOutput($sformatf("vec%0d_underrun", k), {31'd0, underrun}, {31'd0, vecs[k].exp_ur});
    end

    wait_ps(0, 600, "wait_p2");
    measure(0, 256, 1, 24'h0080FF, 1'b1, 24'h101010, 1'b0, 1, 0, "p2_feed");
    measure(0, 256, 1, 24'h101010, 1'b0, 24'h0, 1'b1, 1, 0, "p3_hold");
    measure(0, 256, 1, 24'h101010, 1'b0, 24'h0, 1'b1, 1, 0, "p4_hold");

    // Reset for one clock while the tick counter sits at 100.
    for (int n = 0; n < 99; n++) step();
    rst = 1'b1;
    step();
    checkOutput("midrst_channels", {29'd0, channel_out}, 32'd0);
    checkOutput("midrst_period_start", {31'd0, period_start}, 32'd0);
    checkOutput("midrst_underrun", {31'd0, underrun}, 32'd0);
    checkOutput("midrst_ready", {31'd0, cpixel_ready}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("postrst_ready", {31'd0, cpixel_ready}, 32'd1);
    checkOutput("postrst_channels", {29'd0, channel_out}, 32'd0);
    checkOutput("postrst_underrun", {31'd0, underrun}, 32'd0);
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      get_outputs(0, rdy, ch, ps, ur);
      if (ch !== 3'b000 || ps !== 1'b0 || ur !== 1'b0 || rdy !== 1'b1) bad++;
      step();
    end
    checkOutput("idle_quiet", bad, 0);

`ifdef DISPLAY_PWM_BLANK_EN
    set_valid(0, 1'b1, 24'hFFFFFF);
    step();
    set_valid(0, 1'b0, 24'h0);
    wait_ps(0, 600, "wait_blank");
    measure(0, 256, 1, 24'hFFFFFF, 1'b0, 24'h0, 1'b1, 10, 19, "blank");
`endif

    rst3 = 1'b0;
    step();
    checkOutput("pre3_idle_ready", {31'd0, ready3}, 32'd1);
    set_valid(1, 1'b1, 24'hFF0002);
    step();
    set_valid(1, 1'b0, 24'h0);
    wait_ps(1, 2000, "wait_pre3");
    measure(1, 768, 3, 24'hFF0002, 1'b0, 24'h0, 1'b1, 1, 0, "pre3");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
